// File: rtl/systolic_feeder_if.sv
// Host-side bus of the systolic feeder: operand matrices, start handshake,
// array feed vectors and the captured result.
interface systolic_feeder_if #(parameter int W = 8);
  logic                i_start;
  logic [9*W-1:0]      i_A;
  logic [9*W-1:0]      i_B;
  logic [18*W-1:0]     i_C;
  logic                o_arr_rst_n;
  logic [W-1:0]        o_A11, o_A21, o_A31;
  logic [W-1:0]        o_B11, o_B12, o_B13;
  logic                o_busy;
  logic                o_valid;
  logic [18*W-1:0]     o_C;

  modport slave (
    input  i_start, i_A, i_B, i_C,
    output o_arr_rst_n, o_A11, o_A21, o_A31, o_B11, o_B12, o_B13,
           o_busy, o_valid, o_C
  );

  modport master (
    output i_start, i_A, i_B, i_C,
    input  o_arr_rst_n, o_A11, o_A21, o_A31, o_B11, o_B12, o_B13,
           o_busy, o_valid, o_C
  );
endinterface

// File: rtl/systolic_feeder.sv
// Sequencer for the 3x3 output-stationary MAC array: clear, feed A columns /
// B rows for k=0..2, drain, then capture the result with a one-cycle valid.

module systolic_feeder_lane #(
  parameter int W = 8
) (
  input  logic              i_en,
  input  logic [1:0]        i_k,
  input  logic [2:0][W-1:0] i_arow,
  input  logic [2:0][W-1:0] i_bcol,
  output logic [W-1:0]      o_a,
  output logic [W-1:0]      o_b
);
  always_comb begin
    o_a = '0;
    o_b = '0;
    if (i_en && (i_k != 2'd3)) begin
      o_a = i_arow[i_k];
      o_b = i_bcol[i_k];
    end
  end
endmodule

module systolic_feeder #(
  parameter int DRAIN = 6,
  parameter int W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  systolic_feeder_if.slave   ifc
);
  localparam int CW = $clog2(DRAIN) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [CW-1:0]               r_cnt, w_cnt_nxt;
  logic                        w_latch, w_capture;
  logic [2:0][2:0][W-1:0]      r_A, r_B;
  logic [18*W-1:0]             r_C;

  logic                        w_feed;
  logic [2:0][2:0][W-1:0]      w_bcol;
  logic [2:0][W-1:0]           w_a, w_b;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ifc.i_start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_cnt_nxt   = '0;
      end
      S_FEED: begin
        if (r_cnt == CW'(2)) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        // The array output is settled only after the full drain window.
        if (r_cnt == CW'(DRAIN - 1)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_A <= '0;
      r_B <= '0;
      r_C <= '0;
    end else begin
      if (w_latch) begin
        r_A <= ifc.i_A;
        r_B <= ifc.i_B;
      end
      if (w_capture) r_C <= ifc.i_C;
    end
  end

  assign w_feed = (r_state == S_FEED);

  // Lane g drives row input A[g][k] and column input B[k][g].
  for (genvar g = 0; g < 3; g++) begin : g_lane
    for (genvar k = 0; k < 3; k++) begin : g_tr
      assign w_bcol[g][k] = r_B[k][g];
    end
    systolic_feeder_lane #(.W(W)) u_lane (
      .i_en   (w_feed),
      .i_k    (r_cnt[1:0]),
      .i_arow (r_A[g]),
      .i_bcol (w_bcol[g]),
      .o_a    (w_a[g]),
      .o_b    (w_b[g])
    );
  end

  assign ifc.o_A11 = w_a[0];
  assign ifc.o_A21 = w_a[1];
  assign ifc.o_A31 = w_a[2];
  assign ifc.o_B11 = w_b[0];
  assign ifc.o_B12 = w_b[1];
  assign ifc.o_B13 = w_b[2];

  // Combinational so a block reset clears the array in the same cycle.
  assign ifc.o_arr_rst_n = i_rst_n & (r_state != S_CLEAR);
  assign ifc.o_busy      = (r_state != S_IDLE);
  assign ifc.o_valid     = (r_state == S_DONE);
  assign ifc.o_C         = r_C;
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: behavioural array emulator drives i_C, a schedule
// model predicts every output each cycle, plus literal directed checks.
module tb_systolic_feeder;
  localparam int W     = 8;
  localparam int DRAIN = 6;
  localparam int LAT   = 5 + DRAIN;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  systolic_feeder_if #(.W(W)) ifc ();

  systolic_feeder #(.DRAIN(DRAIN), .W(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .ifc     (ifc)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int vcnt   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [143:0] matmul(input logic [71:0] a, input logic [71:0] b);
    logic [143:0] res;
    logic [15:0]  s, x, y;
    res = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        s = '0;
        for (int k = 0; k < 3; k++) begin
          x = {8'd0, a[(3*r+k)*8 +: 8]};
          y = {8'd0, b[(3*k+c)*8 +: 8]};
          s = s + x * y;
        end
        res[(3*r+c)*16 +: 16] = s;
      end
    return res;
  endfunction

  function automatic logic [71:0] rnd72();
    return 72'({$urandom, $urandom, $urandom});
  endfunction

  // Array emulator: accumulate outer products of the fed vectors, result
  // visible on i_C after a fixed pipeline delay.
  logic [15:0]  acc [9];
  logic [143:0] pipe [5];
  logic [143:0] noise;
  logic [143:0] acc_flat;

  always_comb begin
    acc_flat = '0;
    for (int i = 0; i < 9; i++) acc_flat[i*16 +: 16] = acc[i];
  end

  always @(posedge i_clk) begin
    logic [15:0] a [3];
    logic [15:0] b [3];
    a[0] = {8'd0, ifc.o_A11}; a[1] = {8'd0, ifc.o_A21}; a[2] = {8'd0, ifc.o_A31};
    b[0] = {8'd0, ifc.o_B11}; b[1] = {8'd0, ifc.o_B12}; b[2] = {8'd0, ifc.o_B13};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc[3*r+c] <= (ifc.o_arr_rst_n !== 1'b1) ? 16'd0 : acc[3*r+c] + a[r] * b[c];
    pipe[0] <= acc_flat;
    for (int j = 1; j < 5; j++) pipe[j] <= pipe[j-1];
    noise <= 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
  end

  assign ifc.i_C = (ifc.o_busy === 1'b1) ? pipe[4] : noise;

  // Schedule model: d = cycles since the start was accepted, -1 when idle.
  int           d = -1;
  logic [71:0]  mA = '0, mB = '0;
  logic [143:0] expC = '0;

  always @(posedge i_clk) begin
    cyc++;
    if (!i_rst_n) begin
      d    = -1;
      expC = '0;
    end else if (d < 0) begin
      if (ifc.i_start) begin
        d  = 1;
        mA = ifc.i_A;
        mB = ifc.i_B;
      end
    end else begin
      d++;
      if (d == LAT) expC = matmul(mA, mB);
      else if (d > LAT) d = -1;
    end
  end

  always @(negedge i_clk) begin
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    int k;
    if (ifc.o_valid === 1'b1) vcnt++;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin ea[i] = '0; eb[i] = '0; end
      if (d >= 2 && d <= 4) begin
        k = d - 2;
        for (int i = 0; i < 3; i++) begin
          ea[i] = mA[(3*i+k)*8 +: 8];
          eb[i] = mB[(3*k+i)*8 +: 8];
        end
      end
      chk("busy",      ifc.o_busy, d >= 1);
      chk("valid",     ifc.o_valid, d == LAT);
      chk("arr_rst_n", ifc.o_arr_rst_n, i_rst_n && (d != 1));
      chk("o_C",       ifc.o_C, expC);
      chk("feedA",     {ifc.o_A11, ifc.o_A21, ifc.o_A31}, {ea[0], ea[1], ea[2]});
      chk("feedB",     {ifc.o_B11, ifc.o_B12, ifc.o_B13}, {eb[0], eb[1], eb[2]});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [71:0] a, input logic [71:0] b, output int lat);
    int c0;
    ifc.i_A = a;
    ifc.i_B = b;
    ifc.i_start = 1'b1;
    c0 = cyc;
    tick(1);
    ifc.i_start = 1'b0;
    ifc.i_A = rnd72();
    ifc.i_B = rnd72();
    for (int n = 0; n < 40 && ifc.o_valid !== 1'b1; n++) tick(1);
    lat = cyc - c0;
  endtask

  initial begin
    logic [71:0]  a, b;
    logic [143:0] lit;
    int lat, c1, v0;
    int tA [3][3];
    int tB [3][3];
    tA = '{'{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9}};
    tB = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};

    ifc.i_start = 1'b0;
    ifc.i_A = '0;
    ifc.i_B = '0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_busy",  ifc.o_busy, 1'b0);
    chk("rst_valid", ifc.o_valid, 1'b0);
    chk("rst_C",     ifc.o_C, '0);
    chk("rst_arr",   ifc.o_arr_rst_n, 1'b0);
    i_rst_n = 1'b1;
    tick(1);
    chk("rel_arr",   ifc.o_arr_rst_n, 1'b1);

    // Sequencing with A = 1..9, B = identity
    for (int i = 0; i < 9; i++) begin
      a[i*8 +: 8] = 8'(i + 1);
      b[i*8 +: 8] = (i % 4 == 0) ? 8'd1 : 8'd0;
      lit[i*16 +: 16] = 16'(i + 1);
    end
    ifc.i_A = a;
    ifc.i_B = b;
    ifc.i_start = 1'b1;
    tick(1);
    ifc.i_start = 1'b0;
    ifc.i_A = rnd72();
    for (int s = 1; s <= LAT; s++) begin
      if (s == 1) chk("seq_clear", ifc.o_arr_rst_n, 1'b0);
      if (s >= 2 && s <= 4) begin
        chk("seq_A", {ifc.o_A11, ifc.o_A21, ifc.o_A31},
            {8'(tA[s-2][0]), 8'(tA[s-2][1]), 8'(tA[s-2][2])});
        chk("seq_B", {ifc.o_B11, ifc.o_B12, ifc.o_B13},
            {8'(tB[s-2][0]), 8'(tB[s-2][1]), 8'(tB[s-2][2])});
      end
      if (s >= 5 && s < LAT)
        chk("seq_zero", {ifc.o_A11, ifc.o_A21, ifc.o_A31, ifc.o_B11, ifc.o_B12, ifc.o_B13}, '0);
      if (s == LAT) begin
        chk("seq_valid", ifc.o_valid, 1'b1);
        chk("seq_C", ifc.o_C, lit);
      end
      if (s < LAT) tick(1);
    end
    tick(2);

    // Accumulator clearing: all-2 times all-3 -> every lane 18
    a = {9{8'd2}};
    b = {9{8'd3}};
    run_op(a, b, lat);
    chk("clr_lat", 144'(lat), 144'(11));
    chk("clr_C", ifc.o_C, {9{16'd18}});
    tick(3);
    chk("hold_C", ifc.o_C, {9{16'd18}});

    // Back-to-back with start held high
    ifc.i_A = rnd72();
    ifc.i_B = rnd72();
    ifc.i_start = 1'b1;
    for (int n = 0; n < 40 && ifc.o_valid !== 1'b1; n++) tick(1);
    c1 = cyc;
    tick(1);
    for (int n = 0; n < 40 && ifc.o_valid !== 1'b1; n++) tick(1);
    chk("b2b_period", 144'(cyc - c1), 144'(12));
    ifc.i_start = 1'b0;
    tick(16);

    // Start pulses while busy are ignored
    v0 = vcnt;
    ifc.i_A = rnd72();
    ifc.i_B = rnd72();
    ifc.i_start = 1'b1;
    tick(1);
    ifc.i_start = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      ifc.i_start = (s == 3 || s == 10);
      ifc.i_A = rnd72();
      tick(1);
    end
    ifc.i_start = 1'b0;
    chk("busy_one_valid", 144'(vcnt - v0), 144'(1));

    // Abort during FEED k=1
    ifc.i_A = rnd72();
    ifc.i_B = rnd72();
    ifc.i_start = 1'b1;
    tick(1);
    ifc.i_start = 1'b0;
    tick(2);
    v0 = vcnt;
    i_rst_n = 1'b0;
    tick(1);
    i_rst_n = 1'b1;
    chk("abort_busy", ifc.o_busy, 1'b0);
    chk("abort_C", ifc.o_C, '0);
    tick(15);
    chk("abort_novalid", 144'(vcnt - v0), 144'(0));
    a = rnd72();
    b = rnd72();
    run_op(a, b, lat);
    chk("after_abort_lat", 144'(lat), 144'(11));
    chk("after_abort_C", ifc.o_C, matmul(a, b));
    tick(2);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      ifc.i_start = ($urandom_range(0, 3) == 0);
      ifc.i_A = rnd72();
      ifc.i_B = rnd72();
      i_rst_n = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    i_rst_n = 1'b1;
    ifc.i_start = 1'b0;
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream controller and sequencer for the 3x3 output-stationary systolic MAC array.
- Accepts two 3x3 8-bit matrices A and B on a start strobe and clears the array accumulators.
- Streams column k of A and row k of B for k=0..2, then feeds zeros while the array drains.
- Captures the 144-bit C result and presents it with a one-cycle valid pulse.
- Input skew is done inside the array; this block presents unskewed vectors.

Parameters:
DRAIN, 6, number of zero-feed cycles after the last data cycle before C is captured (min 5)
W, 8, operand width (array is built for 8; result lanes are 2*W)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  start request; accepted only when o_busy=0
i_A  in  72  matrix A, row-major: A[r][c] = i_A[(3r+c)*8 +: 8]
i_B  in  72  matrix B, row-major: B[r][c] = i_B[(3r+c)*8 +: 8]
i_C  in  144  array result bus; lane (3r+c) = C[r][c] at i_C[(3r+c)*16 +: 16]
o_arr_rst_n  out  1  array reset/clear, active-low, to array i_rst_n
o_A11, o_A21, o_A31  out  8 each  row inputs to array
o_B11, o_B12, o_B13  out  8 each  column inputs to array
o_busy  out  1  operation in progress
o_valid  out  1  one-cycle pulse; o_C holds new result
o_C  out  144  captured result, same lane layout as i_C

Behaviour:
- Reset (i_rst_n=0 at a rising edge): state=IDLE, counter=0, latched A/B=0, o_C=0, o_valid=0, o_busy=0, all feed outputs 0.
- o_arr_rst_n = i_rst_n AND NOT(state==CLEAR). It is combinational, so a block reset also clears the array.
- States:
  - IDLE: o_busy=0. If i_start=1, latch i_A and i_B, then go to CLEAR.
  - CLEAR: 1 cycle; o_arr_rst_n=0. Then go to FEED with k=0.
  - FEED: 3 cycles, k=0,1,2.
    - o_A{r+1}1 = A[r][k] for r=0..2.
    - o_B1{c+1} = B[k][c] for c=0..2.
    - After k=2, go to DRAIN.
  - DRAIN: DRAIN cycles with all feed outputs 0. On the edge ending the last DRAIN cycle, o_C <= i_C. Then go to DONE.
  - DONE: 1 cycle; o_valid=1. Then go to IDLE.
- o_busy=1 in CLEAR, FEED, DRAIN and DONE.
- Feed outputs are 0 in every state except FEED. They are combinational from state, k and the latched matrices.
- Timing: start sampled at edge e. CLEAR is the cycle after e, FEED the next 3 cycles, then DRAIN cycles. o_valid is high in cycle e+5+DRAIN (11 cycles after acceptance with default DRAIN).
- i_start while o_busy=1 (including DONE) is ignored and not queued. i_A/i_B may change freely after acceptance.
- Back-to-back operation: i_start held high is re-accepted in the first IDLE cycle after DONE. The next o_valid follows 12 cycles after the previous one (default DRAIN).
- o_C holds its value until the next capture, and is unaffected by i_C changes in between.
- Arithmetic is done entirely by the array (unsigned, wraps mod 2^16 per lane). This block does no arithmetic.
- Reset mid-operation: abort immediately to IDLE and clear o_C. No o_valid is produced for the aborted operation.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles -> o_busy=0, o_valid=0, o_C=0, all feed outputs 0, o_arr_rst_n=0 during reset and 1 after release.
- Sequencing: A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, start -> CLEAR cycle has o_arr_rst_n=0; feed (A11,A21,A31 | B11,B12,B13) = (1,4,7|1,0,0), (2,5,8|0,1,0), (3,6,9|0,0,1); then 6 zero cycles.
- End-to-end with real array: same A and B -> o_valid pulse exactly 11 cycles after start; o_C lanes 0..8 = 1,2,3,4,5,6,7,8,9.
- Accumulator clearing: second run with A=all 2, B=all 3 -> every lane = 18, with no residue from the previous result.
- Start while busy: pulse i_start at cycles +3 and +10 of an operation -> exactly one o_valid; o_busy stays 1 throughout.
- Abort: assert i_rst_n=0 during FEED k=1 -> next cycle IDLE, o_C=0, no o_valid. A new start afterwards completes correctly.
